// File: rtl/mux_scan_collector.sv
// mux_scan_collector
//   Steps the select of a downstream 16:1 single-bit mux through channels
//   0..15, waits SETTLE cycles on each channel and samples the mux output.
//   The 16 samples are assembled into a word that is offered on a
//   valid/ready handshake.
//   Optional feature macro: MUXSCAN_PARITY_EN adds the registered odd-parity
//   output out_parity (XNOR-reduce of out_word).
module mux_scan_collector #(
  parameter int SETTLE = 1  // cycles sel is held per channel, legal 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        y_in,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [15:0] out_word,
  output logic        out_valid,
`ifdef MUXSCAN_PARITY_EN
  output logic        out_parity,
`endif
  input  logic        out_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] work_q,  work_d;
  logic [15:0] word_q,  word_d;
  logic        valid_q, valid_d;
  logic        par_q,   par_d;

  logic        start_ok;
  logic        capture;
  logic [15:0] cap_word;

  // A start is taken only when idle and the output slot is free or being freed.
  assign start_ok = (state_q == ST_IDLE) && start && (!valid_q || out_ready);
  assign capture  = (state_q == ST_SCAN) && (cnt_q == CNT_LAST);

  // Working register with the current sample merged in; used on the final
  // capture so bit 15 lands in out_word on the same edge.
  always_comb begin
    cap_word         = work_q;
    cap_word[idx_q]  = y_in;
  end

  // Next-state logic for the scan sequencer and output handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    word_d  = word_q;
    valid_d = valid_q;
    par_d   = par_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_SCAN;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        if (capture) begin
          work_d = cap_word;
          cnt_d  = 4'd0;
          idx_d  = idx_q + 4'd1;  // wraps 15 -> 0 so sel returns to 0 in IDLE
          if (idx_q == 4'd15) begin
            word_d  = cap_word;
            par_d   = ~^cap_word;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  // State registers; reset aborts any scan and drops the pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      work_q  <= 16'h0000;
      word_q  <= 16'h0000;
      valid_q <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      par_q   <= par_d;
    end
  end

  assign sel       = idx_q;
  assign busy      = (state_q == ST_SCAN);
  assign out_word  = word_q;
  assign out_valid = valid_q;

`ifdef MUXSCAN_PARITY_EN
  assign out_parity = par_q;
`else
  // Parity register is unused without the parity port and is trimmed away.
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_collector.sv
// tb_mux_scan_collector
//   Two instances (SETTLE=1 and SETTLE=3) each fed by a behavioural 16:1 mux
//   (y = inp[sel]). Expected words and completion cycles for the SETTLE=1
//   instance go into a scoreboard queue when a scan is started and are popped
//   when out_valid rises.
module tb_mux_scan_collector;

  typedef struct {
    logic [15:0] word;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start1 = 1'b0, ready1 = 1'b1;
  logic [15:0] inp1 = 16'h0000;
  logic        y1, busy1, valid1;
  logic [3:0]  sel1;
  logic [15:0] word1;

  logic        start3 = 1'b0, ready3 = 1'b1;
  logic [15:0] inp3 = 16'h0000;
  logic        y3, busy3, valid3;
  logic [3:0]  sel3;
  logic [15:0] word3;

`ifdef MUXSCAN_PARITY_EN
  logic        par1, par3;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pushes   = 0;
  int events   = 0;
  logic prev_valid1 = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign y1 = inp1[sel1];
  assign y3 = inp3[sel3];

  mux_scan_collector #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y1), .sel(sel1),
    .busy(busy1), .out_word(word1), .out_valid(valid1),
`ifdef MUXSCAN_PARITY_EN
    .out_parity(par1),
`endif
    .out_ready(ready1)
  );

  mux_scan_collector #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .y_in(y3), .sel(sel3),
    .busy(busy3), .out_word(word3), .out_valid(valid3),
`ifdef MUXSCAN_PARITY_EN
    .out_parity(par3),
`endif
    .out_ready(ready3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the SETTLE=1 instance.
  always @(negedge clk) begin
    if (valid1 && !prev_valid1) begin
      events++;
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_word", 32'(word1), 32'(e.word));
        check("sb_latency", 32'(cyc), 32'(e.cyc));
`ifdef MUXSCAN_PARITY_EN
        check("sb_parity", 32'(par1), 32'(~^e.word));
`endif
      end
    end
    prev_valid1 <= valid1;
  end

  // Full scan on dut1; poke>0 pulses start again after that many busy cycles.
  task automatic do_scan(input logic [15:0] pat, input logic rdy, input int poke);
    exp_t e;
    inp1   = pat;
    ready1 = rdy;
    start1 = 1'b1;
    e.word = pat;
    e.cyc  = cyc + 17;
    sb.push_back(e);
    pushes++;
    tick();                       // E0
    start1 = 1'b0;
    check("busy_after_start", 32'(busy1), 32'd1);
    check("valid_after_start", 32'(valid1), 32'd0);
    for (int i = 1; i <= 15; i++) begin
      start1 = (i == poke);
      tick();
    end
    start1 = 1'b0;
    check("busy_at_15", 32'(busy1), 32'd1);
    check("valid_at_15", 32'(valid1), 32'd0);
    tick();                       // E0+16
    check("busy_done", 32'(busy1), 32'd0);
    check("valid_done", 32'(valid1), 32'd1);
    check("sel_wrap", 32'(sel1), 32'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_sel", 32'(sel1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_word", 32'(word1), 32'd0);
`ifdef MUXSCAN_PARITY_EN
    check("rst_parity", 32'(par1), 32'd0);
`endif

    // Walking one, SETTLE=1
    for (int k = 0; k < 16; k++) begin
      do_scan(16'h0001 << k, 1'b1, 0);
    end
    tick();
    check("walk_valid_cleared", 32'(valid1), 32'd0);

    // Pattern A5C3 on SETTLE=3 instance, sel held 3 cycles per channel
    inp3   = 16'hA5C3;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int t = 0; t < 48; t++) begin
      check("s3_busy", 32'(busy3), 32'd1);
      check("s3_sel", 32'(sel3), 32'(t / 3));
      tick();
    end
    check("s3_valid", 32'(valid3), 32'd1);
    check("s3_busy_done", 32'(busy3), 32'd0);
    check("s3_word", 32'(word3), 32'h0000A5C3);
`ifdef MUXSCAN_PARITY_EN
    check("s3_parity", 32'(par3), 32'd1);
`endif

    // Back-pressure: word 1234 held, start dropped
    do_scan(16'h1234, 1'b0, 0);
    inp1   = 16'hFFFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("bp_busy", 32'(busy1), 32'd0);
    check("bp_valid", 32'(valid1), 32'd1);
    check("bp_word", 32'(word1), 32'h00001234);
    repeat (20) tick();
    check("bp_busy_later", 32'(busy1), 32'd0);
    check("bp_word_later", 32'(word1), 32'h00001234);
    check("bp_valid_later", 32'(valid1), 32'd1);

    // Accept and restart on the same edge
    do_scan(16'h00FF, 1'b1, 0);
    tick();
    check("ar_valid_cleared", 32'(valid1), 32'd0);

    // Reset mid-scan
    inp1   = 16'h5555;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (6) tick();
    check("mid_busy_before_rst", 32'(busy1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_sel", 32'(sel1), 32'd0);
    check("mid_rst_valid", 32'(valid1), 32'd0);
    check("mid_rst_word", 32'(word1), 32'd0);
    repeat (20) tick();
    check("mid_rst_no_valid", 32'(valid1), 32'd0);
    do_scan(16'hBEEF, 1'b1, 0);
    tick();

    // start while busy: exactly one completion
    do_scan(16'h3C5A, 1'b1, 5);
    tick();
    repeat (30) tick();
    check("busy_start_idle", 32'(busy1), 32'd0);
    check("busy_start_valid", 32'(valid1), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("valid_events", 32'(events), 32'(pushes));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
